// File: rtl/riscv151_pkg.sv
// Shared constants for the Riscv151 core: datapath width, reset vector,
// canonical NOP and the base opcodes seen by the front end and decode.
package riscv151_pkg;

    localparam int          RV_XLEN     = 32;
    localparam logic [31:0] RV_PC_RESET = 32'h0000_2000;
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_STYPE  = 7'b0100011;
    localparam logic [6:0] OPC_BTYPE  = 7'b1100011;
    localparam logic [6:0] OPC_JTYPE  = 7'b1101111;
    localparam logic [6:0] OPC_JRTYPE = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding {instruction, pc} entries between icache and decode.
// Caller guarantees no push when full and no pop when empty.
module fetch_queue
    import riscv151_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2 * RV_XLEN,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign count     = cnt;

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one icache read per
// cycle under queue credit, and buffers responses for decode.
module riscv_fetch_unit
    import riscv151_pkg::*;
#(
    parameter int              XLEN     = RV_XLEN,
    parameter logic [XLEN-1:0] PC_RESET = XLEN'(RV_PC_RESET),
    parameter int              IQ_DEPTH = 4,
    localparam int CW = $clog2(IQ_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    output logic [XLEN-1:0] icache_addr,
    output logic            icache_re,
    input  logic [XLEN-1:0] icache_dout,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            deq_ready,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [CW-1:0]   iq_count
);

    logic [XLEN-1:0]   fpc;
    logic              inflight;
    logic [XLEN-1:0]   inflight_pc;

    logic              accept;
    logic              redir;
    logic              pop_req;
    logic              issue;
    logic              q_push;
    logic              q_pop;
    logic [XLEN-1:0]   target;
    logic [CW:0]       occ_next;
    logic [2*XLEN-1:0] head;
    logic              unused_addr_bits;

    assign accept  = !stall;
    assign redir   = accept && redirect_valid;
    assign pop_req = accept && inst_valid && deq_ready;
    assign target  = {redirect_pc[XLEN-1:2], 2'b00};

    assign unused_addr_bits = ^redirect_pc[1:0];

    // Credit looks at occupancy after this cycle's pop or flush, so a draining
    // or redirected queue can issue in the same cycle.
    always_comb begin
        occ_next = '0;
        if (!redir) begin
            occ_next = {1'b0, iq_count} - (CW+1)'(pop_req) + (CW+1)'(inflight);
        end
    end

    assign icache_re   = !reset && (occ_next < (CW+1)'(IQ_DEPTH));
    assign icache_addr = redir ? target : fpc;
    assign issue       = accept && icache_re;

    assign q_push = accept && inflight && !redir;
    assign q_pop  = pop_req && !redir;

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc         <= PC_RESET;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (accept) begin
            if (issue) begin
                fpc         <= icache_addr + XLEN'(4);
                inflight    <= 1'b1;
                inflight_pc <= icache_addr;
            end else begin
                inflight <= 1'b0;
                if (redir) begin
                    fpc <= target;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (IQ_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data ({icache_dout, inflight_pc}),
        .pop       (q_pop),
        .flush     (redir),
        .head_data (head),
        .count     (iq_count)
    );

    assign inst_valid = (iq_count != '0);
    assign inst       = head[2*XLEN-1:XLEN];
    assign inst_pc    = head[XLEN-1:0];

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit; the memory model answers each read
// with the inverted address one cycle later.
module tb_riscv_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        deq_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [2:0]  iq_count;

    int checks = 0;
    int errors = 0;

    riscv_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .icache_addr    (icache_addr),
        .icache_re      (icache_re),
        .icache_dout    (icache_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_ready      (deq_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .iq_count       (iq_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!stall && icache_re) icache_dout <= ~icache_addr;
    end

    task automatic drive(input logic rst, input logic st, input logic rv,
                         input logic [31:0] rpc, input logic dr);
        @(negedge clk);
        reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc; deq_ready = dr;
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        checks++; if (icache_re !== 1'b0) begin errors++; $display("FAIL reset_re_low: got %b expected 0", icache_re); end
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        checks++; if (icache_re !== 1'b1) begin errors++; $display("FAIL reset_re: got %b expected 1", icache_re); end
        checks++; if (icache_addr !== 32'h2000) begin errors++; $display("FAIL reset_addr: got %h expected 00002000", icache_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        checks++; if (iq_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", iq_count); end
        checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL reset_head: got inst %h pc %h expected 0/0", inst, inst_pc); end
    endtask

    task automatic test_startup();
        logic [31:0] exp_pc;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 0, 1);
            checks++; if (icache_addr !== 32'h2000 + 32'(4*k) || icache_re !== 1'b1) begin errors++; $display("FAIL start_issue k=%0d: got %h/%b expected %h/1", k, icache_addr, icache_re, 32'h2000 + 32'(4*k)); end
            checks++; if (inst_valid !== (k >= 2) || iq_count !== ((k >= 2) ? 3'd1 : 3'd0)) begin errors++; $display("FAIL start_occ k=%0d: got valid %b count %0d", k, inst_valid, iq_count); end
            if (k >= 2) begin
                exp_pc = 32'h2000 + 32'(4*(k-2));
                checks++; if (inst_pc !== exp_pc || inst !== ~exp_pc) begin errors++; $display("FAIL start_head k=%0d: got %h/%h expected %h/%h", k, inst_pc, inst, exp_pc, ~exp_pc); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_cnt;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0, 0);
            exp_cnt = (k < 2) ? 3'd0 : 3'(k - 1);
            checks++; if (icache_re !== (k < 4) || iq_count !== exp_cnt) begin errors++; $display("FAIL bp_fill k=%0d: got re %b count %0d expected %b/%0d", k, icache_re, iq_count, (k < 4), exp_cnt); end
        end
        checks++; if (inst_pc !== 32'h2000) begin errors++; $display("FAIL bp_head: got %h expected 00002000", inst_pc); end
        drive(0, 0, 0, 0, 1);
        checks++; if (icache_re !== 1'b1 || icache_addr !== 32'h2010) begin errors++; $display("FAIL bp_release: got re %b addr %h expected 1/00002010", icache_re, icache_addr); end
        checks++; if (inst_pc !== 32'h2000 || iq_count !== 3'd4) begin errors++; $display("FAIL bp_release_head: got %h count %0d expected 00002000/4", inst_pc, iq_count); end
        for (int k = 1; k < 7; k++) begin
            drive(0, 0, 0, 0, 1);
            checks++; if (inst_pc !== 32'h2000 + 32'(4*k) || iq_count !== 3'd3) begin errors++; $display("FAIL bp_drain k=%0d: got %h count %0d expected %h/3", k, inst_pc, iq_count, 32'h2000 + 32'(4*k)); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 32'h3002, 0);
        checks++; if (icache_addr !== 32'h3000 || icache_re !== 1'b1) begin errors++; $display("FAIL redir_issue: got %h/%b expected 00003000/1", icache_addr, icache_re); end
        checks++; if (iq_count !== 3'd3) begin errors++; $display("FAIL redir_precount: got %0d expected 3", iq_count); end
        drive(0, 0, 0, 0, 0);
        checks++; if (iq_count !== 3'd0 || inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got count %0d valid %b expected 0/0", iq_count, inst_valid); end
        checks++; if (icache_addr !== 32'h3004) begin errors++; $display("FAIL redir_next: got %h expected 00003004", icache_addr); end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1);
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h3000 + 32'(4*k) || inst !== ~(32'h3000 + 32'(4*k))) begin errors++; $display("FAIL redir_head k=%0d: got %b %h/%h expected pc %h", k, inst_valid, inst_pc, inst, 32'h3000 + 32'(4*k)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0, 1);
            checks++; if (inst_pc !== 32'h200C || icache_addr !== 32'h2014 || iq_count !== 3'd1 || icache_re !== 1'b1) begin errors++; $display("FAIL stall_frozen k=%0d: got pc %h addr %h count %0d re %b", k, inst_pc, icache_addr, iq_count, icache_re); end
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 1);
            checks++; if (inst_pc !== 32'h200C + 32'(4*k) || icache_addr !== 32'h2014 + 32'(4*k)) begin errors++; $display("FAIL stall_resume k=%0d: got pc %h addr %h expected %h/%h", k, inst_pc, icache_addr, 32'h200C + 32'(4*k), 32'h2014 + 32'(4*k)); end
        end
    endtask

    task automatic test_corner();
        do_reset();
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 1, 32'h4000, 1);
            checks++; if (icache_addr !== 32'h2010 || inst_pc !== 32'h2008) begin errors++; $display("FAIL stalled_redir k=%0d: got addr %h pc %h expected 00002010/00002008", k, icache_addr, inst_pc); end
        end
        drive(0, 0, 1, 32'h4000, 1);
        checks++; if (icache_addr !== 32'h4000) begin errors++; $display("FAIL redir_after_stall: got %h expected 00004000", icache_addr); end
        drive(0, 0, 0, 0, 1);
        checks++; if (iq_count !== 3'd0 || icache_addr !== 32'h4004) begin errors++; $display("FAIL redir_after_stall_flush: got count %0d addr %h", iq_count, icache_addr); end
        drive(0, 0, 1, 32'h5000, 1);
        checks++; if (inst_pc !== 32'h4000 || inst_valid !== 1'b1 || icache_addr !== 32'h5000) begin errors++; $display("FAIL redir_pop_pre: got pc %h valid %b addr %h", inst_pc, inst_valid, icache_addr); end
        drive(0, 0, 0, 0, 1);
        checks++; if (iq_count !== 3'd0 || inst_valid !== 1'b0) begin errors++; $display("FAIL redir_pop_flush: got count %0d valid %b expected 0/0", iq_count, inst_valid); end
        drive(0, 0, 1, 32'hFFFF_FFFF, 1);
        checks++; if (inst_pc !== 32'h5000 || icache_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_issue: got pc %h addr %h expected 00005000/fffffffc", inst_pc, icache_addr); end
        drive(0, 0, 0, 0, 1);
        checks++; if (icache_addr !== 32'h0000_0000 || iq_count !== 3'd0) begin errors++; $display("FAIL wrap_next: got addr %h count %0d expected 0/0", icache_addr, iq_count); end
        drive(0, 0, 0, 0, 1);
        checks++; if (inst_pc !== 32'hFFFF_FFFC || inst !== 32'h3 || icache_addr !== 32'h4) begin errors++; $display("FAIL wrap_head0: got pc %h inst %h addr %h", inst_pc, inst, icache_addr); end
        drive(0, 0, 0, 0, 1);
        checks++; if (inst_pc !== 32'h0 || inst !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_head1: got pc %h inst %h expected 0/ffffffff", inst_pc, inst); end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, 0);
        checks++; if (iq_count !== 3'd4) begin errors++; $display("FAIL mid_full: got %0d expected 4", iq_count); end
        drive(1, 0, 0, 0, 0);
        checks++; if (icache_re !== 1'b0) begin errors++; $display("FAIL mid_re_low: got %b expected 0", icache_re); end
        drive(0, 0, 0, 0, 1);
        checks++; if (iq_count !== 3'd0 || inst_valid !== 1'b0 || icache_addr !== 32'h2000 || icache_re !== 1'b1) begin errors++; $display("FAIL mid_restart: got count %0d valid %b addr %h re %b", iq_count, inst_valid, icache_addr, icache_re); end
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h2000 || inst !== ~32'h2000) begin errors++; $display("FAIL mid_first: got %b %h/%h expected pc 00002000", inst_valid, inst_pc, inst); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_stall();
        test_corner();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
